// File: rtl/stream_mux4_1.sv
// stream_mux4_1: merges four valid/ready input streams into one registered output stream.
// Each output word is tagged with the index of the channel it came from.
// Arbitration is round-robin by default, or fixed priority (ch0 highest) when FIXED_PRIO=1.
// The output stage is a one-entry register. It reloads in the same cycle it is drained,
// so the block can pass one word per cycle without a bubble.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data0-3 per-channel input words
//   in_valid   bit k set: channel k offers in_data<k>
//   in_ready   bit k set: channel k word accepted this cycle (one-hot or zero)
//   out_data   registered merged word
//   out_sel    source channel of out_data
//   out_valid  out_data/out_sel hold a valid word
//   out_ready  downstream accepts the word this cycle
module stream_mux4_1 #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;

  logic             load;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             do_grant;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Arbiter: pick one valid channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    if (FIXED_PRIO) begin
      // Walk downwards so the lowest set index is the one left standing.
      for (int k = 3; k >= 0; k--) begin
        if (in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = 2'(k);
        end
      end
    end else begin
      // Search starts one past the last winner. Offset 4 wraps back to the last winner itself.
      for (int off = 1; off <= 4; off++) begin
        cand = last_grant_q + 2'(off);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  assign load     = (state_q == StEmpty) | (out_valid & out_ready);
  // Gating with rst_n keeps in_ready low for the whole time reset is asserted.
  assign do_grant = load & grant_vld & rst_n;
  assign in_ready = do_grant ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    sel_d        = sel_q;
    if (do_grant) begin
      state_d = StFull;
      data_d  = grant_data;
      sel_d   = grant_idx;
      if (!FIXED_PRIO) begin
        last_grant_d = grant_idx;
      end
    end else if (out_valid && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      last_grant_q <= 2'd3;
      data_q       <= '0;
      sel_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
    end
  end

endmodule

// File: tb/tb_stream_mux4_1.sv
// Self-checking bench for stream_mux4_1.
// Two instances share one set of inputs: one round-robin and one fixed-priority.
// The reference model keeps the round-robin order as a rotating list of channels.
// The list front is the highest-priority channel. After a grant, the list rotates
// until the winner sits at the back.
module tb_stream_mux4_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din [4];
  logic [3:0]  in_valid = 4'b0;
  logic        out_ready = 1'b0;

  logic [3:0]  rdy [2];
  logic [15:0] od [2];
  logic [1:0]  os [2];
  logic        ov [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux4_1 #(.WIDTH(16), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(out_ready)
  );

  stream_mux4_1 #(.WIDTH(16), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(out_ready)
  );

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  logic        m_valid [2];
  logic [15:0] m_data [2];
  logic [1:0]  m_sel [2];
  int          order [4];
  int          g_pred [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = 16'h0;
      m_sel[m]   = 2'd0;
      g_pred[m]  = -1;
    end
    for (int i = 0; i < 4; i++) order[i] = i;
  endtask

  function automatic int predict(input int m);
    if (m_valid[m] && !out_ready) return -1;
    if (in_valid == 4'b0) return -1;
    if (m == 1) begin
      for (int k = 0; k < 4; k++) if (in_valid[k]) return k;
    end else begin
      for (int i = 0; i < 4; i++) if (in_valid[order[i]]) return order[i];
    end
    return -1;
  endfunction

  // Inputs are driven at the falling edge. Outputs are compared 1 ns later.
  task automatic settle_check();
    logic [3:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      g_pred[m] = predict(m);
      er = (g_pred[m] >= 0) ? (4'b0001 << g_pred[m]) : 4'b0000;
      chk($sformatf("model_in_ready[%0d]", m), 32'(rdy[m]), 32'(er));
      chk($sformatf("model_out_valid[%0d]", m), 32'(ov[m]), 32'(m_valid[m]));
      if (m_valid[m]) begin
        chk($sformatf("model_out_data[%0d]", m), 32'(od[m]), 32'(m_data[m]));
        chk($sformatf("model_out_sel[%0d]", m), 32'(os[m]), 32'(m_sel[m]));
      end
    end
  endtask

  task automatic advance();
    int tmp;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (g_pred[m] >= 0) begin
        m_valid[m] = 1'b1;
        m_data[m]  = din[g_pred[m]];
        m_sel[m]   = 2'(g_pred[m]);
        if (m == 0) begin
          while (order[3] != g_pred[m]) begin
            tmp = order[0];
            for (int i = 0; i < 3; i++) order[i] = order[i+1];
            order[3] = tmp;
          end
        end
      end else if (m_valid[m] && out_ready) begin
        m_valid[m] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] rdy_rr;
    logic [3:0] rdy_fp;
    logic       ov;
    logic [1:0] sel_rr;
    logic [1:0] sel_fp;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit accepted;
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, 2'd0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b1, 2'd1, 2'd0};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b1, 2'd2, 2'd0};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd3, 2'd0};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 2'd0};
    tbl[6] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'd0, 2'd0};
    tbl[7] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd3, 2'd3};
    tbl[8] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[9] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 2'd1};

    for (int k = 0; k < 4; k++) din[k] = 16'h0;
    model_reset();

    // Reset state, with every channel offering a word.
    in_valid = 4'b1111;
    #2;
    chk("reset_in_ready_rr", 32'(rdy[0]), 32'h0);
    chk("reset_in_ready_fp", 32'(rdy[1]), 32'h0);
    chk("reset_out_valid", 32'(ov[0]), 32'h0);
    chk("reset_out_data", 32'(od[0]), 32'h0);
    chk("reset_out_sel", 32'(os[0]), 32'h0);
    @(negedge clk);
    do_reset();

    // Single word from ch2.
    in_valid = 4'b0100; din[2] = 16'hBEEF; out_ready = 1'b1;
    settle_check();
    chk("single_in_ready", 32'(rdy[0]), 32'h4);
    advance();
    in_valid = 4'b0000;
    settle_check();
    chk("single_out_valid", 32'(ov[0]), 32'h1);
    chk("single_out_data", 32'(od[0]), 32'hBEEF);
    chk("single_out_sel", 32'(os[0]), 32'h2);
    advance();

    // Table: full throughput rotation, then wrap from ch3.
    do_reset();
    for (int k = 0; k < 4; k++) din[k] = 16'h00A0 + 16'(k);
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      settle_check();
      chk($sformatf("tbl%0d_rdy_rr", i), 32'(rdy[0]), 32'(tbl[i].rdy_rr));
      chk($sformatf("tbl%0d_rdy_fp", i), 32'(rdy[1]), 32'(tbl[i].rdy_fp));
      chk($sformatf("tbl%0d_ov_rr", i), 32'(ov[0]), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_ov_fp", i), 32'(ov[1]), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_sel_rr", i), 32'(os[0]), 32'(tbl[i].sel_rr));
        chk($sformatf("tbl%0d_sel_fp", i), 32'(os[1]), 32'(tbl[i].sel_fp));
        chk($sformatf("tbl%0d_data_rr", i), 32'(od[0]), 32'(16'h00A0 + 16'(tbl[i].sel_rr)));
      end
      advance();
    end

    // Backpressure after a ch1 grant.
    do_reset();
    in_valid = 4'b0010; din[1] = 16'h1111; out_ready = 1'b1;
    settle_check();
    advance();
    din[1] = 16'h2222; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle_check();
      chk("bp_in_ready", 32'(rdy[0]), 32'h0);
      chk("bp_out_data", 32'(od[0]), 32'h1111);
      chk("bp_out_sel", 32'(os[0]), 32'h1);
      advance();
    end
    out_ready = 1'b1;
    settle_check();
    chk("bp_release_in_ready", 32'(rdy[0]), 32'h2);
    advance();
    in_valid = 4'b0000;
    settle_check();
    chk("bp_next_data", 32'(od[0]), 32'h2222);
    advance();

    // Fixed priority: ch0 starves ch3 while valid.
    do_reset();
    in_valid = 4'b1001; out_ready = 1'b1; din[0] = 16'h0C00; din[3] = 16'h3C00;
    for (int c = 0; c < 3; c++) begin
      settle_check();
      chk("fp_ch0_grant", 32'(rdy[1]), 32'h1);
      advance();
      din[0] = din[0] + 16'h1;
    end
    in_valid = 4'b1000;
    settle_check();
    chk("fp_ch3_grant", 32'(rdy[1]), 32'h8);
    advance();
    in_valid = 4'b0000;
    settle_check();
    advance();

    // Reset mid-stream while holding a word.
    in_valid = 4'b1111; out_ready = 1'b0;
    settle_check();
    advance();
    settle_check();
    chk("mid_pre_valid", 32'(ov[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out_valid_rr", 32'(ov[0]), 32'h0);
    chk("mid_rst_out_valid_fp", 32'(ov[1]), 32'h0);
    chk("mid_rst_in_ready_rr", 32'(rdy[0]), 32'h0);
    chk("mid_rst_in_ready_fp", 32'(rdy[1]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    settle_check();
    chk("mid_after_rst_ch0", 32'(rdy[0]), 32'h1);
    advance();

    // Random traffic. Producers hold their words until the round-robin instance accepts them.
    in_valid = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      settle_check();
      advance();
      for (int k = 0; k < 4; k++) begin
        accepted = (g_pred[0] == k);
        if (!in_valid[k] || accepted) begin
          in_valid[k] = ($urandom_range(0, 1) == 1);
          din[k] = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          in_valid[k] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
